// File: rtl/decoder_nx2n_pipe_pkg.sv
// Shared definitions for the pipelined N-to-2^N decoder.
//   state_e      : occupancy of the output/skid storage (EMPTY, ONE, TWO)
//   params_legal : elaboration-time legality check for SEL_W / NUM_OUT
package decoder_nx2n_pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    // SEL_W must be 1..6 and NUM_OUT must be 2..2**SEL_W.
    function automatic bit params_legal(input int sel_w, input int num_out);
        return (sel_w >= 1) && (sel_w <= 6) &&
               (num_out >= 2) && (num_out <= (1 << sel_w));
    endfunction

endpackage

// File: rtl/decoder_nx2n_comb.sv
// Purely combinational decode f(sel, en).
// Ports:
//   sel    in  SEL_W    index to decode
//   en     in  1        decode enable
//   onehot out NUM_OUT  bit k = en & (sel == k); bit 0 forced low when MASK_ZERO
//   err    out 1        en & (sel >= NUM_OUT)
module decoder_nx2n_comb #(
    parameter int SEL_W     = 3,
    parameter int NUM_OUT   = 8,
    parameter int MASK_ZERO = 0
) (
    input  logic [SEL_W-1:0]   sel,
    input  logic               en,
    output logic [NUM_OUT-1:0] onehot,
    output logic               err
);

    always_comb begin
        onehot = '0;
        err    = en && (int'(sel) >= NUM_OUT);
        // An out-of-range index matches no k, so the vector is all zeros on error.
        for (int k = 0; k < NUM_OUT; k++) begin
            onehot[k] = en && (int'(sel) == k);
        end
        // R0 write suppression: index 0 is legal, just never asserted.
        if (MASK_ZERO != 0) begin
            onehot[0] = 1'b0;
        end
    end

endmodule

// File: rtl/decoder_nx2n_pipe.sv
// Pipelined decoder: combinational decode at the input, then a 2-entry
// (output register + skid register) valid/ready buffer, 1-cycle latency.
// Ports:
//   CLK       in  1        clock, rising edge
//   RST_N     in  1        asynchronous active-low reset
//   IN        in  SEL_W    index to decode
//   EN        in  1        decode enable
//   IN_VALID  in  1        upstream transaction valid
//   IN_READY  out 1        registered; low only when both entries are full
//   OUT       out NUM_OUT  registered one-hot result
//   OUT_ERR   out 1        current output had IN >= NUM_OUT
//   OUT_VALID out 1        OUT/OUT_ERR hold a valid transaction
//   OUT_READY in  1        downstream accepts the transaction
module decoder_nx2n_pipe
    import decoder_nx2n_pipe_pkg::*;
#(
    parameter int SEL_W     = 3,
    parameter int NUM_OUT   = 8,
    parameter int MASK_ZERO = 0
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [SEL_W-1:0]   IN,
    input  logic               EN,
    input  logic               IN_VALID,
    output logic               IN_READY,
    output logic [NUM_OUT-1:0] OUT,
    output logic               OUT_ERR,
    output logic               OUT_VALID,
    input  logic               OUT_READY
);

    if (!params_legal(SEL_W, NUM_OUT)) begin : g_bad_params
        $error("decoder_nx2n_pipe: illegal SEL_W/NUM_OUT combination");
    end

    logic [NUM_OUT-1:0] dec_onehot_p0;
    logic               dec_err_p0;

    state_e             state_p1;
    state_e             state_nxt;
    logic               in_ready_p1;
    logic [NUM_OUT-1:0] out_onehot_p1;
    logic               out_err_p1;
    logic [NUM_OUT-1:0] skid_onehot_p1;
    logic               skid_err_p1;

    logic accept;
    logic transfer;
    logic load_out_in;
    logic load_out_skid;
    logic load_skid;

    // ---- stage p0: combinational decode of the incoming transaction ----
    decoder_nx2n_comb #(
        .SEL_W     (SEL_W),
        .NUM_OUT   (NUM_OUT),
        .MASK_ZERO (MASK_ZERO)
    ) u_comb (
        .sel    (IN),
        .en     (EN),
        .onehot (dec_onehot_p0),
        .err    (dec_err_p0)
    );

    assign accept    = IN_VALID && in_ready_p1;
    assign transfer  = OUT_VALID && OUT_READY;
    assign OUT_VALID = (state_p1 != EMPTY);
    assign IN_READY  = in_ready_p1;
    assign OUT       = out_onehot_p1;
    assign OUT_ERR   = out_err_p1;

    always_comb begin
        state_nxt     = state_p1;
        load_out_in   = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        case (state_p1)
            EMPTY: begin
                if (accept) begin
                    state_nxt   = ONE;
                    load_out_in = 1'b1;
                end
            end
            ONE: begin
                if (accept && transfer) begin
                    load_out_in = 1'b1;
                end else if (accept) begin
                    state_nxt = TWO;
                    load_skid = 1'b1;
                end else if (transfer) begin
                    state_nxt = EMPTY;
                end
            end
            TWO: begin
                // IN_READY is low here, so only a drain can happen.
                if (transfer) begin
                    state_nxt     = ONE;
                    load_out_skid = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // ---- stage p1: output register, skid register and occupancy ----
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_p1       <= EMPTY;
            in_ready_p1    <= 1'b1;
            out_onehot_p1  <= '0;
            out_err_p1     <= 1'b0;
            skid_onehot_p1 <= '0;
            skid_err_p1    <= 1'b0;
        end else begin
            state_p1    <= state_nxt;
            // Registered ready: no combinational path from OUT_READY.
            in_ready_p1 <= (state_nxt != TWO);
            if (load_out_in) begin
                out_onehot_p1 <= dec_onehot_p0;
                out_err_p1    <= dec_err_p0;
            end else if (load_out_skid) begin
                out_onehot_p1 <= skid_onehot_p1;
                out_err_p1    <= skid_err_p1;
            end
            if (load_skid) begin
                skid_onehot_p1 <= dec_onehot_p0;
                skid_err_p1    <= dec_err_p0;
            end
        end
    end

endmodule

// File: tb/tb_decoder_nx2n_pipe.sv
// Scoreboard bench: four configurations of decoder_nx2n_pipe share one clock
// and reset. Stimulus pushes hand-computed {err, onehot} into a per-instance
// queue on accept; a monitor pops and compares on every output transfer and
// checks output stability while stalled.
module tb_decoder_nx2n_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // instance 0: SEL_W=3 NUM_OUT=8; 1: NUM_OUT=6; 2: MASK_ZERO=1; 3: SEL_W=4 NUM_OUT=16
    logic [2:0] sel0, sel1, sel2;
    logic [3:0] sel3;
    logic en0, en1, en2, en3;
    logic iv0, iv1, iv2, iv3;
    logic ordy0, ordy1, ordy2, ordy3;
    logic irdy0, irdy1, irdy2, irdy3;
    logic vld0, vld1, vld2, vld3;
    logic err0, err1, err2, err3;
    logic [7:0]  out0;
    logic [5:0]  out1;
    logic [7:0]  out2;
    logic [15:0] out3;

    logic [3:0]  irdy_v, vld_v, err_v, ordy_v;
    logic [15:0] o16 [4];
    assign irdy_v = {irdy3, irdy2, irdy1, irdy0};
    assign vld_v  = {vld3, vld2, vld1, vld0};
    assign err_v  = {err3, err2, err1, err0};
    assign ordy_v = {ordy3, ordy2, ordy1, ordy0};
    assign o16[0] = {8'b0, out0};
    assign o16[1] = {10'b0, out1};
    assign o16[2] = {8'b0, out2};
    assign o16[3] = out3;

    decoder_nx2n_pipe #(.SEL_W(3), .NUM_OUT(8), .MASK_ZERO(0)) u_base (
        .CLK(clk), .RST_N(rst_n), .IN(sel0), .EN(en0), .IN_VALID(iv0), .IN_READY(irdy0),
        .OUT(out0), .OUT_ERR(err0), .OUT_VALID(vld0), .OUT_READY(ordy0));
    decoder_nx2n_pipe #(.SEL_W(3), .NUM_OUT(6), .MASK_ZERO(0)) u_n6 (
        .CLK(clk), .RST_N(rst_n), .IN(sel1), .EN(en1), .IN_VALID(iv1), .IN_READY(irdy1),
        .OUT(out1), .OUT_ERR(err1), .OUT_VALID(vld1), .OUT_READY(ordy1));
    decoder_nx2n_pipe #(.SEL_W(3), .NUM_OUT(8), .MASK_ZERO(1)) u_mz (
        .CLK(clk), .RST_N(rst_n), .IN(sel2), .EN(en2), .IN_VALID(iv2), .IN_READY(irdy2),
        .OUT(out2), .OUT_ERR(err2), .OUT_VALID(vld2), .OUT_READY(ordy2));
    decoder_nx2n_pipe #(.SEL_W(4), .NUM_OUT(16), .MASK_ZERO(0)) u_w4 (
        .CLK(clk), .RST_N(rst_n), .IN(sel3), .EN(en3), .IN_VALID(iv3), .IN_READY(irdy3),
        .OUT(out3), .OUT_ERR(err3), .OUT_VALID(vld3), .OUT_READY(ordy3));

    int checks = 0;
    int passed = 0;
    bit rand_on = 1'b0;

    logic [16:0] q0[$], q1[$], q2[$], q3[$];

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endfunction

    function automatic void chk_fail(input string nm);
        checks++;
        $display("FAIL %s at %0t", nm, $time);
    endfunction

    function automatic void push_exp(input int i, input logic [16:0] v);
        case (i)
            0: q0.push_back(v);
            1: q1.push_back(v);
            2: q2.push_back(v);
            default: q3.push_back(v);
        endcase
    endfunction

    function automatic int q_size(input int i);
        case (i)
            0: return q0.size();
            1: return q1.size();
            2: return q2.size();
            default: return q3.size();
        endcase
    endfunction

    function automatic logic [16:0] pop_exp(input int i);
        case (i)
            0: return q0.pop_front();
            1: return q1.pop_front();
            2: return q2.pop_front();
            default: return q3.pop_front();
        endcase
    endfunction

    task automatic drive(input int i, input int idx, input bit e, input bit v);
        case (i)
            0: begin sel0 = 3'(idx); en0 = e; iv0 = v; end
            1: begin sel1 = 3'(idx); en1 = e; iv1 = v; end
            2: begin sel2 = 3'(idx); en2 = e; iv2 = v; end
            default: begin sel3 = 4'(idx); en3 = e; iv3 = v; end
        endcase
    endtask

    // Presents one transaction, waits (bounded) for IN_READY, returns #1 after the accepting edge.
    task automatic send(input int i, input int idx, input bit e, input logic [15:0] eo, input bit ee);
        int n;
        drive(i, idx, e, 1'b1);
        n = 0;
        @(negedge clk);
        while (!irdy_v[i]) begin
            n++;
            if (n > 200) begin
                chk_fail("send_timeout");
                drive(i, 0, 1'b0, 1'b0);
                return;
            end
            @(negedge clk);
        end
        push_exp(i, {ee, eo});
        @(posedge clk);
        #1;
        drive(i, 0, 1'b0, 1'b0);
    endtask

    // Monitor: compares at the negedge before each transferring posedge.
    bit          stalled [4];
    logic [16:0] last    [4];
    initial begin : monitor
        logic [16:0] act;
        for (int i = 0; i < 4; i++) begin stalled[i] = 1'b0; last[i] = '0; end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (!rst_n || !vld_v[i]) begin
                    stalled[i] = 1'b0;
                end else begin
                    act = {err_v[i], o16[i]};
                    if (stalled[i]) chk($sformatf("stable%0d", i), 32'(act), 32'(last[i]));
                    if (ordy_v[i]) begin
                        if (q_size(i) == 0) chk_fail($sformatf("unexpected_out%0d got 0x%0h", i, act));
                        else chk($sformatf("out%0d", i), 32'(act), 32'(pop_exp(i)));
                        stalled[i] = 1'b0;
                    end else begin
                        stalled[i] = 1'b1;
                        last[i]    = act;
                    end
                end
            end
        end
    end

    // Random back-pressure for the wide instance during the sweep.
    initial begin : stall_gen
        ordy3 = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ordy3 = rand_on ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) drive(i, 0, 1'b0, 1'b0);
        ordy0 = 1'b1; ordy1 = 1'b1; ordy2 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out", 32'(out0), 0);
        chk("rst_vld", 32'(vld0), 0);
        chk("rst_err", 32'(err0), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_irdy", 32'(irdy_v), 32'hF);

        // Single transaction, 1-cycle latency, then drained.
        send(0, 5, 1'b1, 16'h0020, 1'b0);
        chk("lat_vld", 32'(vld0), 1);
        chk("lat_out", 32'(out0), 32'h20);
        @(posedge clk);
        #1;
        chk("lat_drain", 32'(vld0), 0);

        // Back-pressure fills both entries.
        ordy0 = 1'b0;
        send(0, 1, 1'b1, 16'h0002, 1'b0);
        send(0, 2, 1'b1, 16'h0004, 1'b0);
        chk("bp_irdy_low", 32'(irdy0), 0);
        chk("bp_hold", 32'(out0), 32'h02);
        repeat (3) @(posedge clk);
        #1;
        ordy0 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("bp_irdy_back", 32'(irdy0), 1);
        chk("bp_drained", 32'(q0.size()), 0);

        // NUM_OUT=6: out-of-range, disabled, top legal index, index 0.
        send(1, 7, 1'b1, 16'h0000, 1'b1);
        send(1, 7, 1'b0, 16'h0000, 1'b0);
        send(1, 5, 1'b1, 16'h0020, 1'b0);
        send(1, 6, 1'b1, 16'h0000, 1'b1);
        send(1, 0, 1'b1, 16'h0001, 1'b0);

        // MASK_ZERO=1.
        send(2, 0, 1'b1, 16'h0000, 1'b0);
        send(2, 1, 1'b1, 16'h0002, 1'b0);
        send(2, 7, 1'b1, 16'h0080, 1'b0);

        // Full sweep with random stalls.
        rand_on = 1'b1;
        for (int k = 0; k < 16; k++) send(3, k, 1'b1, 16'(1 << k), 1'b0);
        rand_on = 1'b0;
        n = 0;
        while ((q_size(1) + q_size(2) + q_size(3)) != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("sweep_drained", 32'(q_size(1) + q_size(2) + q_size(3)), 0);

        // Asynchronous reset while holding two entries.
        ordy0 = 1'b0;
        send(0, 3, 1'b1, 16'h0008, 1'b0);
        send(0, 4, 1'b1, 16'h0010, 1'b0);
        chk("pre_rst_irdy", 32'(irdy0), 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_vld", 32'(vld0), 0);
        chk("arst_out", 32'(out0), 0);
        chk("arst_err", 32'(err0), 0);
        q0.delete();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        ordy0 = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("post_rst_irdy", 32'(irdy0), 1);
        chk("post_rst_idle", 32'(vld0), 0);
        send(0, 6, 1'b1, 16'h0040, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("final_drained", 32'(q_size(0) + q_size(1) + q_size(2) + q_size(3)), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
